// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: ALU select codes,
// FSM state encodings and the restoring-divide step used by the divider core.
package muldiv_unit_pkg;

  localparam int XLEN = 32;

  // Base ALU select codes
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;

  // RV32M select codes
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;
  // func3=101 is the unsigned divide, historically named DIVH in ALU control
  localparam logic [4:0] ALU_DIVH   = ALU_DIVU;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_MUL  = 3'd1,
    MD_DIVI = 3'd2,
    MD_DIVF = 3'd3,
    MD_FIN  = 3'd4
  } md_state_t;

  // Edges from accept to the done cycle for an iterative divide
  localparam int MD_DIV_LAT = XLEN + 2;

  localparam logic [XLEN-1:0] MD_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // One restoring-division step: shift in the next dividend bit, subtract the
  // divisor if it fits. Returns {remainder, quotient-shift-register}.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                 input logic [XLEN-1:0] quot,
                                                 input logic [XLEN-1:0] divisor);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    shifted = {rem, quot[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[XLEN])
      return {diff[XLEN-1:0], quot[XLEN-2:0], 1'b1};
    else
      return {shifted[XLEN-1:0], quot[XLEN-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Iterative unsigned restoring divider: the load cycle resolves the first
// quotient bit, the remaining bits follow one per cycle, ready after XLEN cycles.
module muldiv_div_core
  import muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem,
  output logic            ready
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  divisor_q;
  logic [CNT_W-1:0] count;
  logic             run;

  // count holds the number of quotient bits already resolved
  always_ff @(posedge clk) begin
    if (rst) begin
      quot      <= '0;
      rem       <= '0;
      divisor_q <= '0;
      count     <= '0;
      run       <= 1'b0;
      ready     <= 1'b0;
    end else if (load) begin
      {rem, quot} <= div_step('0, dividend, divisor);
      divisor_q   <= divisor;
      count       <= CNT_W'(1);
      run         <= 1'b1;
      ready       <= 1'b0;
    end else if (run) begin
      {rem, quot} <= div_step(rem, quot, divisor_q);
      count       <= count + CNT_W'(1);
      if (count == CNT_W'(XLEN - 1)) begin
        run   <= 1'b0;
        ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute unit beside the EX-stage ALU: multi-cycle multiply/divide with
// a start/busy/done handshake so the hazard unit can hold the instruction.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      ALUsel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_t state;

  logic            is_mul;
  logic            is_div;
  logic            rem_op;
  logic            sgn_a;
  logic            sgn_b;
  logic            neg_a;
  logic            neg_b;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic            accept;
  logic            div_load;
  logic [XLEN-1:0] special_val;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  logic              hi_q;
  logic              rem_q;
  logic              negq_q;
  logic              negr_q;
  logic [2*XLEN-1:0] ma_q;
  logic [2*XLEN-1:0] mb_q;
  logic [2*XLEN-1:0] prod;

  logic [XLEN-1:0] div_quot;
  logic [XLEN-1:0] div_rem;
  logic            div_ready;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    rem_op = 1'b0;
    sgn_a  = 1'b0;
    sgn_b  = 1'b0;
    case (ALUsel)
      ALU_MUL:    is_mul = 1'b1;
      ALU_MULH:   begin is_mul = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      ALU_MULHSU: begin is_mul = 1'b1; sgn_a = 1'b1; end
      ALU_MULHU:  is_mul = 1'b1;
      ALU_DIV:    begin is_div = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      ALU_DIVU:   is_div = 1'b1;
      ALU_REM:    begin is_div = 1'b1; rem_op = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      ALU_REMU:   begin is_div = 1'b1; rem_op = 1'b1; end
      default:    ;
    endcase
  end

  assign neg_a = sgn_a & a[XLEN-1];
  assign neg_b = sgn_b & b[XLEN-1];
  assign mag_a = neg_a ? -a : a;
  assign mag_b = neg_b ? -b : b;

  // Architecturally defined divide results that bypass the iterative core;
  // the signed-overflow quotient happens to equal the dividend itself
  assign div_zero    = (b == '0);
  assign div_ovf     = sgn_b && (a == MD_INT_MIN) && (b == '1);
  assign special     = is_div && (div_zero || div_ovf);
  assign special_val = div_zero ? (rem_op ? a : '1) : (rem_op ? '0 : a);

  assign accept   = (state == MD_IDLE) && start && (is_mul || is_div) && !kill;
  assign div_load = accept && is_div && !special;

  // Operands are held sign/zero-extended to 2*XLEN so the low product bits are exact
  assign prod = ma_q * mb_q;

  muldiv_div_core u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quot     (div_quot),
    .rem      (div_rem),
    .ready    (div_ready)
  );

  // A flush aborts any in-flight op without touching result; FIN completes regardless
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MD_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      hi_q   <= 1'b0;
      rem_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      ma_q   <= '0;
      mb_q   <= '0;
    end else begin
      done <= 1'b0;
      if (kill && state != MD_IDLE && state != MD_FIN) begin
        state <= MD_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          MD_IDLE: begin
            if (accept) begin
              busy   <= 1'b1;
              hi_q   <= (ALUsel != ALU_MUL);
              rem_q  <= rem_op;
              negq_q <= neg_a ^ neg_b;
              negr_q <= neg_a;
              ma_q   <= {{XLEN{neg_a}}, a};
              mb_q   <= {{XLEN{neg_b}}, b};
              if (special) begin
                result <= special_val;
                done   <= 1'b1;
                state  <= MD_FIN;
              end else if (is_mul) begin
                state <= MD_MUL;
              end else begin
                state <= MD_DIVI;
              end
            end
          end
          MD_MUL: begin
            result <= hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
            done   <= 1'b1;
            state  <= MD_FIN;
          end
          MD_DIVI: begin
            if (div_ready)
              state <= MD_DIVF;
          end
          MD_DIVF: begin
            if (rem_q)
              result <= negr_q ? -div_rem : div_rem;
            else
              result <= negq_q ? -div_quot : div_quot;
            done  <= 1'b1;
            state <= MD_FIN;
          end
          MD_FIN: begin
            busy  <= 1'b0;
            state <= MD_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= MD_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table-driven op vectors plus directed
// sequences for reset, kill, start-while-busy and back-to-back issue.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [4:0]  alusel;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ALUsel (alusel),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Presents one request for a single accept edge; returns #1 after that edge
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] av,
                               input logic [31:0] bv);
    @(negedge clk);
    start  = 1'b1;
    alusel = op;
    a      = av;
    b      = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int first, output int lat, output bit busy_ok);
    lat     = first;
    busy_ok = 1'b1;
    while (!done && lat <= 40) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) lat = -1;
    else if (!busy) busy_ok = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  ok;
    int  ndone;

    vecs[0]  = '{"mul_3x4",      ALU_MUL,    32'd3,        32'd4,        32'd12,       2};
    vecs[1]  = '{"mulh_min",     ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 2};
    vecs[2]  = '{"mulhsu_ones",  ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2};
    vecs[3]  = '{"mulhu_ones",   ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2};
    vecs[4]  = '{"mul_ones",     ALU_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 2};
    vecs[5]  = '{"div_m7_2",     ALU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    vecs[6]  = '{"rem_m7_2",     ALU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    vecs[7]  = '{"divu_big_2",   ALU_DIVH,   32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 34};
    vecs[8]  = '{"remu_100_7",   ALU_REMU,   32'd100,      32'd7,        32'd2,        34};
    vecs[9]  = '{"div_min_3",    ALU_DIV,    32'h80000000, 32'd3,        32'hD5555556, 34};
    vecs[10] = '{"div_by0",      ALU_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[11] = '{"remu_by0",     ALU_REMU,   32'd5,        32'd0,        32'd5,        1};
    vecs[12] = '{"div_ovf",      ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[13] = '{"rem_ovf",      ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[14] = '{"divu_by0",     ALU_DIVU,   32'd9,        32'd0,        32'hFFFFFFFF, 1};

    rst    = 1'b1;
    start  = 1'b0;
    kill   = 1'b0;
    alusel = ALU_ADD;
    a      = '0;
    b      = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitDone(1, lat, ok);
      checkOutput({vecs[i].name, "_result"}, result, vecs[i].exp);
      checkOutput({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
      checkOutput({vecs[i].name, "_busy_held"}, 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
      checkOutput({vecs[i].name, "_busy_drop"}, 32'(busy), 32'd0);
    end

    // Reset in the middle of a divide
    applyStimulus(ALU_DIV, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(ALU_MUL, 32'd3, 32'd4);
    waitDone(1, lat, ok);
    checkOutput("postrst_mul_result", result, 32'd12);
    checkOutput("postrst_mul_latency", 32'(lat), 32'd2);

    // Kill at cycle 5 of a divide
    applyStimulus(ALU_DIV, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    checkOutput("kill_busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int c = 0; c < MD_DIV_LAT + 4; c++) begin
      if (done) ndone++;
      @(posedge clk);
      #1;
    end
    checkOutput("kill_no_done", 32'(ndone), 32'd0);
    checkOutput("kill_result_held", result, 32'd12);

    // kill together with start in IDLE must not accept
    @(negedge clk);
    start  = 1'b1;
    kill   = 1'b1;
    alusel = ALU_MUL;
    a      = 32'd2;
    b      = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    kill  = 1'b0;
    checkOutput("killstart_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("killstart_result", result, 32'd12);

    // start while busy is ignored
    applyStimulus(ALU_DIVU, 32'hFFFFFFF9, 32'd2);
    @(negedge clk);
    start  = 1'b1;
    alusel = ALU_MUL;
    a      = 32'd7;
    b      = 32'd9;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b0;
    waitDone(4, lat, ok);
    checkOutput("busystart_result", result, 32'h7FFFFFFC);
    checkOutput("busystart_latency", 32'(lat), 32'(MD_DIV_LAT));
    checkOutput("busystart_busy_held", 32'(ok), 32'd1);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    checkOutput("busystart_no_replay", 32'(ndone), 32'd0);

    // Back-to-back: start held high, second op accepted the cycle after done
    @(negedge clk);
    start  = 1'b1;
    alusel = ALU_MUL;
    a      = 32'd6;
    b      = 32'd7;
    @(posedge clk);
    #1;
    waitDone(1, lat, ok);
    checkOutput("b2b_mul_result", result, 32'd42);
    checkOutput("b2b_mul_latency", 32'(lat), 32'd2);
    alusel = ALU_DIVU;
    a      = 32'd100;
    b      = 32'd7;
    @(posedge clk);
    #1;
    checkOutput("b2b_idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b_accept_busy", 32'(busy), 32'd1);
    waitDone(1, lat, ok);
    checkOutput("b2b_divu_result", result, 32'd14);
    checkOutput("b2b_divu_latency", 32'(lat), 32'(MD_DIV_LAT));

    // Non-M select never raises busy
    @(negedge clk);
    start  = 1'b1;
    alusel = ALU_ADD;
    a      = 32'd1;
    b      = 32'd1;
    ndone  = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (busy || done) ndone++;
    end
    start = 1'b0;
    checkOutput("add_never_busy", 32'(ndone), 32'd0);
    checkOutput("add_result_held", result, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
